// File: rtl/eda_neighbor_stack.sv
// LIFO work-stack for the regional-maxima flood fill: takes 8-neighbour push batches,
// serialises them one entry per cycle, and pops the next center pixel on request.
module eda_neighbor_stack #(
    parameter int unsigned M          = 16,
    parameter int unsigned N          = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(M * N),
    parameter int unsigned DEPTH      = M * N,
    parameter int unsigned CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              push_positions,
    input  logic [8*ADDR_WIDTH-1:0] neighbor_addrs,
    input  logic                    pop_req,
    output logic                    pop_valid,
    output logic [ADDR_WIDTH-1:0]   pop_addr,
    output logic                    empty,
    output logic                    full,
    output logic [CNT_WIDTH-1:0]    count,
    output logic                    overflow
);

    localparam int unsigned PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              mask_q, mask_d;
    logic [8*ADDR_WIDTH-1:0] addrs_q, addrs_d;
    logic [CNT_WIDTH-1:0]    count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic                    pop_valid_q, pop_valid_d;
    logic [ADDR_WIDTH-1:0]   pop_addr_q, pop_addr_d;
    logic [ADDR_WIDTH-1:0]   stack_q [DEPTH];

    logic [2:0]              sel_idx;
    logic [7:0]              mask_rest;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [PTR_WIDTH-1:0]    wr_ptr;
    logic [PTR_WIDTH-1:0]    top_ptr;
    logic                    wr_en;
    logic                    is_empty;
    logic                    is_full;
    logic                    pop_fire;

    // Highest set bit of the remaining mask: upleft is pushed first.
    always_comb begin
        sel_idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (mask_q[k]) sel_idx = 3'(k);
        end
    end

    assign mask_rest = mask_q & ~(8'd1 << sel_idx);
    assign sel_addr  = addrs_q[32'(sel_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    assign is_empty  = (count_q == '0);
    assign is_full   = (count_q == CNT_WIDTH'(DEPTH));
    assign wr_ptr    = count_q[PTR_WIDTH-1:0];
    assign top_ptr   = PTR_WIDTH'(count_q - CNT_WIDTH'(1));
    assign pop_fire  = !clear && (state_q == S_IDLE) && pop_req && !is_empty;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid && (push_positions != 8'd0)) state_d = S_LOAD;
                S_LOAD: if (mask_rest == 8'd0) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        in_ready = (state_q == S_IDLE);
    end

    // Datapath next-state: capture, serialise, pop, flush
    always_comb begin
        mask_d      = mask_q;
        addrs_d     = addrs_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        pop_valid_d = 1'b0;
        pop_addr_d  = pop_addr_q;
        wr_en       = 1'b0;
        if (clear) begin
            mask_d     = 8'd0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (state_q == S_IDLE) begin
            if (in_valid) begin
                mask_d  = push_positions;
                addrs_d = neighbor_addrs;
            end
            if (pop_fire) begin
                pop_addr_d  = stack_q[top_ptr];
                count_d     = count_q - CNT_WIDTH'(1);
                pop_valid_d = 1'b1;
            end
        end else begin
            mask_d = mask_rest;
            if (is_full) begin
                overflow_d = 1'b1;
            end else begin
                wr_en   = 1'b1;
                count_d = count_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q      <= 8'd0;
            addrs_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            pop_valid_q <= 1'b0;
            pop_addr_q  <= '0;
        end else begin
            mask_q      <= mask_d;
            addrs_q     <= addrs_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            pop_valid_q <= pop_valid_d;
            pop_addr_q  <= pop_addr_d;
        end
    end

    // Stack storage is left unreset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) stack_q[wr_ptr] <= sel_addr;
    end

    assign pop_valid = pop_valid_q;
    assign pop_addr  = pop_addr_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign empty     = is_empty;
    assign full      = is_full;

endmodule

// File: tb/tb_eda_neighbor_stack.sv
// Bench for eda_neighbor_stack (DEPTH=4): directed scenarios plus random traffic
// against a queue-based LIFO model.
module tb_eda_neighbor_stack;

    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    push_positions = 8'd0;
    logic [8*AW-1:0] neighbor_addrs = '0;
    logic          pop_req = 1'b0;
    logic          pop_valid;
    logic [AW-1:0] pop_addr;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    // Reference model: stored entries, pending batch entries, sticky flag, last pop
    logic [7:0] mdl_stack[$];
    logic [7:0] mdl_pend[$];
    logic       mdl_ovf = 1'b0;
    logic       mdl_pv  = 1'b0;
    logic [7:0] mdl_pa  = 8'd0;

    eda_neighbor_stack #(.M(16), .N(16), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .push_positions(push_positions), .neighbor_addrs(neighbor_addrs),
        .pop_req(pop_req), .pop_valid(pop_valid), .pop_addr(pop_addr),
        .empty(empty), .full(full), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        check("in_ready",  32'(in_ready),  32'(mdl_pend.size() == 0));
        check("count",     32'(count),     32'(mdl_stack.size()));
        check("empty",     32'(empty),     32'(mdl_stack.size() == 0));
        check("full",      32'(full),      32'(mdl_stack.size() == DEPTH));
        check("overflow",  32'(overflow),  32'(mdl_ovf));
        check("pop_valid", 32'(pop_valid), 32'(mdl_pv));
        check("pop_addr",  32'(pop_addr),  32'(mdl_pa));
    endtask

    // One clock: apply inputs, advance the model, check after the edge
    task automatic tick(input logic cl, input logic iv, input logic [7:0] m,
                        input logic [8*AW-1:0] a, input logic pr);
        clear = cl; in_valid = iv; push_positions = m; neighbor_addrs = a; pop_req = pr;
        if (cl) begin
            mdl_stack.delete(); mdl_pend.delete(); mdl_ovf = 1'b0; mdl_pv = 1'b0;
        end else if (mdl_pend.size() == 0) begin
            mdl_pv = 1'b0;
            if (pr && mdl_stack.size() > 0) begin
                mdl_pa = mdl_stack.pop_back();
                mdl_pv = 1'b1;
            end
            if (iv) begin
                for (int k = 7; k >= 0; k--) if (m[k]) mdl_pend.push_back(a[k*AW +: AW]);
            end
        end else begin
            logic [7:0] e;
            mdl_pv = 1'b0;
            e = mdl_pend.pop_front();
            if (mdl_stack.size() < DEPTH) mdl_stack.push_back(e);
            else mdl_ovf = 1'b1;
        end
        @(posedge clk); #1;
        check_model();
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0; pop_req = 1'b0;
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 8'd0, '0, 1'b0);
    endtask

    task automatic pop();
        tick(1'b0, 1'b0, 8'd0, '0, 1'b1);
    endtask

    task automatic flush();
        tick(1'b1, 1'b0, 8'd0, '0, 1'b0);
    endtask

    initial begin
        logic [8*AW-1:0] a;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        // 1 Reset
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_empty",     32'(empty),     32'd1);
        check("rst_full",      32'(full),      32'd0);
        check("rst_count",     32'(count),     32'd0);
        check("rst_pop_valid", 32'(pop_valid), 32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);

        // 2 Batch with upleft and downright
        a = '0; a[7*AW +: AW] = 8'h11; a[0 +: AW] = 8'h33;
        tick(1'b0, 1'b1, 8'h81, a, 1'b0);
        check("b_ready1", 32'(in_ready), 32'd0);
        idle();
        check("b_ready2", 32'(in_ready), 32'd0);
        idle();
        check("b_ready3", 32'(in_ready), 32'd1);
        check("b_count",  32'(count),    32'd2);
        pop();
        check("b_pv1", 32'(pop_valid), 32'd1);
        check("b_pa1", 32'(pop_addr),  32'h33);
        pop();
        check("b_pv2", 32'(pop_valid), 32'd1);
        check("b_pa2", 32'(pop_addr),  32'h11);

        // 3 Pop while empty, pop during LOAD
        pop();
        check("e_pv",    32'(pop_valid), 32'd0);
        check("e_count", 32'(count),     32'd0);
        tick(1'b0, 1'b1, 8'h81, a, 1'b0);
        pop();
        check("l_pv1", 32'(pop_valid), 32'd0);
        pop();
        check("l_pv2",   32'(pop_valid), 32'd0);
        check("l_count", 32'(count),     32'd2);
        flush();

        // 4 Overfill DEPTH with a full mask
        for (int k = 0; k < 8; k++) a[k*AW +: AW] = 8'(8'hA0 + k);
        tick(1'b0, 1'b1, 8'hFF, a, 1'b0);
        for (int c = 0; c < 8; c++) begin
            check("f_busy", 32'(in_ready), 32'd0);
            idle();
        end
        check("f_ready", 32'(in_ready), 32'd1);
        check("f_count", 32'(count),    32'd4);
        check("f_full",  32'(full),     32'd1);
        check("f_ovf",   32'(overflow), 32'd1);
        for (int k = 4; k < 8; k++) begin
            pop();
            check("f_pa", 32'(pop_addr), 32'(8'hA0 + k));
        end
        flush();

        // 5 Clear mid-LOAD
        tick(1'b0, 1'b1, 8'hF0, a, 1'b0);
        idle();
        flush();
        check("c_count", 32'(count),    32'd0);
        check("c_ready", 32'(in_ready), 32'd1);
        check("c_empty", 32'(empty),    32'd1);
        pop();
        check("c_pv", 32'(pop_valid), 32'd0);

        // 6 Simultaneous pop and capture
        a = '0; a[3*AW +: AW] = 8'h05;
        tick(1'b0, 1'b1, 8'h08, a, 1'b0);
        idle();
        a[3*AW +: AW] = 8'h06;
        tick(1'b0, 1'b1, 8'h08, a, 1'b1);
        check("s_pv", 32'(pop_valid), 32'd1);
        check("s_pa", 32'(pop_addr),  32'h05);
        idle();
        check("s_count", 32'(count), 32'd1);
        pop();
        check("s_pa2", 32'(pop_addr), 32'h06);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            logic [7:0] m;
            a = {$urandom(), $urandom()};
            m = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom());
            tick(($urandom_range(0, 40) == 0), ($urandom_range(0, 2) == 0), m, a,
                 ($urandom_range(0, 1) == 1));
        end

        // Asynchronous reset in the middle of a batch
        tick(1'b0, 1'b1, 8'hFF, a, 1'b0);
        idle();
        reset_n = 1'b0;
        #1;
        check("ar_ready", 32'(in_ready),  32'd1);
        check("ar_count", 32'(count),     32'd0);
        check("ar_ovf",   32'(overflow),  32'd0);
        check("ar_pv",    32'(pop_valid), 32'd0);
        check("ar_pa",    32'(pop_addr),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
